onehot_decoder_seq: RTL and testbench



---
 rtl/decoder_pkg.sv | 17 +
 rtl/dwell_timer.sv | 55 +++++
 rtl/onehot_decoder_seq.sv | 141 ++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot decoder family.
//   - mode encodings for the 2-bit mode input
//   - onehot(): binary index (up to 6 bits) to a 64-bit one-hot vector;
//     callers truncate the result to their own output width.
package decoder_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Widest supported index is 6 bits, so 64 output lines.
  function automatic logic [63:0] onehot(input logic [5:0] i);
    onehot = 64'd1 << i;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the scan modes.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count this cycle (scan active)
//   clr        : treat the counter as zero this cycle (mode switch / direct)
//   dwell      : step threshold; step fires when the counter >= dwell
//   step       : combinational step request for this cycle
//   cnt        : current counter value
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step,
  output logic [DWELL_W-1:0] cnt
);

  logic [DWELL_W-1:0] cnt_r;
  logic [DWELL_W-1:0] cnt_eff;

  assign cnt = cnt_r;

  // Effective count honours a same-cycle clear; >= lets a shrunken dwell force a step.
  always_comb begin
    cnt_eff = {DWELL_W{1'b0}};
    if (clr) begin
      cnt_eff = {DWELL_W{1'b0}};
    end else begin
      cnt_eff = cnt_r;
    end
    step = en && (cnt_eff >= dwell);
  end

  // Counter register: restarts on a step, holds while not counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {DWELL_W{1'b0}};
    end else if (en) begin
      if (step) begin
        cnt_r <= {DWELL_W{1'b0}};
      end else begin
        // cnt_eff < dwell here, so the increment cannot overflow.
        cnt_r <= cnt_eff + DWELL_W'(1);
      end
    end else if (clr) begin
      cnt_r <= {DWELL_W{1'b0}};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with direct, scan-up, scan-down and
// hold modes.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : block enable (0 blanks the output, freezes idx and dwell count)
//   mode       : 00 direct, 01 scan-up, 10 scan-down, 11 hold
//   sel        : index decoded in direct mode
//   dwell      : extra cycles per scan step
//   out        : registered one-hot output, zero when not valid
//   idx        : registered binary index of the active line
//   valid      : out carries a live one-hot value
//   wrap       : one-cycle pulse when a scan wraps around the ends
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 4,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  logic [OUT_W-1:0] out_r, out_nxt;
  logic [SEL_W-1:0] idx_r, idx_nxt;
  logic             valid_r, valid_nxt;
  logic             wrap_r, wrap_nxt;
  logic [1:0]       mode_prev_r;
  logic             mode_chg;
  logic             scan_on;
  logic             tmr_clr;
  logic             step;
  logic [DWELL_W-1:0] cnt;

  assign out   = out_r;
  assign idx   = idx_r;
  assign valid = valid_r;
  assign wrap  = wrap_r;

  // Timer control: count only while scanning; clear on direct or on a mode switch.
  always_comb begin
    mode_chg = (mode != mode_prev_r);
    scan_on  = en && ((mode == MODE_UP) || (mode == MODE_DOWN));
    if (en) begin
      tmr_clr = (mode == MODE_DIRECT) || mode_chg;
    end else begin
      tmr_clr = 1'b0;
    end
  end

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scan_on),
    .clr   (tmr_clr),
    .dwell (dwell),
    .step  (step),
    .cnt   (cnt)
  );

  // Next-state decode of index, output vector, valid and wrap.
  always_comb begin
    idx_nxt   = idx_r;
    out_nxt   = out_r;
    valid_nxt = valid_r;
    wrap_nxt  = 1'b0;
    if (!en) begin
      out_nxt   = {OUT_W{1'b0}};
      valid_nxt = 1'b0;
    end else begin
      case (mode)
        MODE_DIRECT: begin
          idx_nxt   = sel;
          valid_nxt = 1'b1;
          out_nxt   = OUT_W'(onehot(6'(sel)));
        end
        MODE_UP: begin
          valid_nxt = 1'b1;
          if (step) begin
            idx_nxt  = idx_r + SEL_W'(1);
            wrap_nxt = (idx_r == {SEL_W{1'b1}});
          end else begin
            idx_nxt  = idx_r;
          end
          out_nxt = OUT_W'(onehot(6'(idx_nxt)));
        end
        MODE_DOWN: begin
          valid_nxt = 1'b1;
          if (step) begin
            idx_nxt  = idx_r - SEL_W'(1);
            wrap_nxt = (idx_r == {SEL_W{1'b0}});
          end else begin
            idx_nxt  = idx_r;
          end
          out_nxt = OUT_W'(onehot(6'(idx_nxt)));
        end
        MODE_HOLD: begin
          idx_nxt   = idx_r;
          out_nxt   = out_r;
          valid_nxt = valid_r;
        end
        default: begin
          idx_nxt   = idx_r;
          out_nxt   = out_r;
          valid_nxt = valid_r;
        end
      endcase
    end
  end

  // Output and mode-history registers; mode history freezes while disabled
  // so that re-enabling in the same mode resumes the scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r       <= {OUT_W{1'b0}};
      idx_r       <= {SEL_W{1'b0}};
      valid_r     <= 1'b0;
      wrap_r      <= 1'b0;
      mode_prev_r <= MODE_DIRECT;
    end else begin
      out_r   <= out_nxt;
      idx_r   <= idx_nxt;
      valid_r <= valid_nxt;
      wrap_r  <= wrap_nxt;
      if (en) begin
        mode_prev_r <= mode;
      end else begin
        mode_prev_r <= mode_prev_r;
      end
    end
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
module tb_onehot_decoder_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic [7:0]  dwell;
  logic [15:0] out;
  logic [3:0]  idx;
  logic        valid;
  logic        wrap;
  logic [3:0]  out2;
  logic [1:0]  idx2;
  logic        valid2;
  logic        wrap2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  idx;
    logic        valid;
    logic        wrap;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [3:0]  m_idx   = 4'd0;
  logic [7:0]  m_cnt   = 8'd0;
  logic [1:0]  m_prev  = 2'b00;
  logic [15:0] m_out   = 16'd0;
  logic        m_valid = 1'b0;
  logic        m_wrap  = 1'b0;

  onehot_decoder_seq #(.SEL_W(4), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .out(out), .idx(idx), .valid(valid), .wrap(wrap)
  );

  onehot_decoder_seq #(.SEL_W(2), .DWELL_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .dwell(dwell),
    .out(out2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, push expectation, wait to next negedge.
  task automatic tick(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] s, input logic [7:0] d);
    logic [7:0] c;
    exp_t x;
    rst_n = r; en = e; mode = m; sel = s; dwell = d;
    m_wrap = 1'b0;
    if (!r) begin
      m_idx = 4'd0; m_cnt = 8'd0; m_prev = 2'b00; m_out = 16'd0; m_valid = 1'b0;
    end else if (!e) begin
      m_out = 16'd0; m_valid = 1'b0;
    end else begin
      c = (m != m_prev) ? 8'd0 : m_cnt;
      m_prev = m;
      case (m)
        2'b00: begin
          m_idx = s; m_cnt = 8'd0; m_valid = 1'b1; m_out = 16'd1 << s;
        end
        2'b01, 2'b10: begin
          if (c >= d) begin
            if (m == 2'b01) begin
              m_wrap = (m_idx == 4'd15);
              m_idx  = m_idx + 4'd1;
            end else begin
              m_wrap = (m_idx == 4'd0);
              m_idx  = m_idx - 4'd1;
            end
            m_cnt = 8'd0;
          end else begin
            m_cnt = c + 8'd1;
          end
          m_valid = 1'b1;
          m_out = 16'd1 << m_idx;
        end
        default: begin
          m_cnt = c;
        end
      endcase
    end
    x.out = m_out; x.idx = m_idx; x.valid = m_valid; x.wrap = m_wrap;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Scoreboard monitor: compare registered outputs just after each rising edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      checks++;
      if (out !== x.out || idx !== x.idx || valid !== x.valid || wrap !== x.wrap) begin
        errors++;
        $display("FAIL scoreboard t=%0t got out=%h idx=%0d valid=%b wrap=%b expected out=%h idx=%0d valid=%b wrap=%b",
                 $time, out, idx, valid, wrap, x.out, x.idx, x.valid, x.wrap);
      end
      checks++;
      if ((valid === 1'b1 && out !== (16'd1 << idx)) || (valid === 1'b0 && out !== 16'd0)) begin
        errors++;
        $display("FAIL invariant t=%0t out=%h idx=%0d valid=%b", $time, out, idx, valid);
      end
    end
  end

  task automatic test_reset();
    tick(1'b0, 1'b0, 2'b00, 4'd0, 8'd0);
    tick(1'b0, 1'b1, 2'b01, 4'd7, 8'd0);
    checks++;
    if (out !== 16'd0 || idx !== 4'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got out=%h idx=%0d valid=%b wrap=%b expected 0000/0/0/0", out, idx, valid, wrap);
    end
  endtask

  task automatic test_direct_sweep();
    logic [15:0] e;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1, 2'b00, 4'(i), 8'd0);
      e = 16'd1 << i;
      checks++;
      if (out !== e || valid !== 1'b1 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL direct_%0d got out=%h valid=%b wrap=%b expected out=%h valid=1 wrap=0", i, out, valid, wrap, e);
      end
    end
  endtask

  task automatic test_scan_up();
    logic [3:0] exp_idx [9] = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd1};
    int wraps = 0;
    tick(1'b1, 1'b1, 2'b00, 4'd14, 8'd2);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd2);
      if (wrap === 1'b1) wraps++;
      checks++;
      if (idx !== exp_idx[i]) begin
        errors++;
        $display("FAIL scan_up_step%0d got idx=%0d expected %0d", i, idx, exp_idx[i]);
      end
      if (i == 5) begin
        checks++;
        if (out !== 16'h0001 || wrap !== 1'b1) begin
          errors++;
          $display("FAIL scan_up_wrap got out=%h wrap=%b expected out=0001 wrap=1", out, wrap);
        end
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL scan_up_wrap_count got %0d expected 1", wraps);
    end
  endtask

  task automatic test_scan_down();
    logic [3:0] exp_idx [3] = '{4'd0, 4'd15, 4'd14};
    tick(1'b1, 1'b1, 2'b00, 4'd1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 2'b10, 4'd0, 8'd0);
      checks++;
      if (idx !== exp_idx[i] || wrap !== (i == 1)) begin
        errors++;
        $display("FAIL scan_down_step%0d got idx=%0d wrap=%b expected idx=%0d wrap=%b", i, idx, wrap, exp_idx[i], (i == 1));
      end
    end
  endtask

  task automatic test_enable_hold();
    tick(1'b1, 1'b1, 2'b00, 4'd4, 8'd0);
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (idx !== 4'd5) begin
      errors++;
      $display("FAIL en_reach5 got idx=%0d expected 5", idx);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 2'b01, 4'd0, 8'd0);
      checks++;
      if (out !== 16'd0 || valid !== 1'b0 || idx !== 4'd5) begin
        errors++;
        $display("FAIL en_off%0d got out=%h valid=%b idx=%0d expected 0000/0/5", i, out, valid, idx);
      end
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (idx !== 4'd6 || out !== 16'h0040) begin
      errors++;
      $display("FAIL en_resume got idx=%0d out=%h expected 6/0040", idx, out);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 2'b11, 4'd0, 8'd0);
      checks++;
      if (out !== 16'h0040 || valid !== 1'b1 || idx !== 4'd6 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d got out=%h valid=%b idx=%0d expected 0040/1/6", i, out, valid, idx);
      end
    end
  endtask

  task automatic test_dwell_shrink();
    tick(1'b1, 1'b1, 2'b00, 4'd0, 8'd10);
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd10);
    checks++;
    if (idx !== 4'd0) begin
      errors++;
      $display("FAIL shrink_before got idx=%0d expected 0", idx);
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd3);
    checks++;
    if (idx !== 4'd1) begin
      errors++;
      $display("FAIL shrink_force got idx=%0d expected 1", idx);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd3);
    checks++;
    if (idx !== 4'd1) begin
      errors++;
      $display("FAIL shrink_dwell got idx=%0d expected 1", idx);
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd3);
    checks++;
    if (idx !== 4'd2) begin
      errors++;
      $display("FAIL shrink_period got idx=%0d expected 2", idx);
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    tick(1'b0, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (out !== 16'd0 || idx !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got out=%h idx=%0d valid=%b expected 0000/0/0", out, idx, valid);
    end
    // hold straight out of reset keeps valid low
    tick(1'b1, 1'b1, 2'b11, 4'd0, 8'd0);
    checks++;
    if (valid !== 1'b0 || out !== 16'd0) begin
      errors++;
      $display("FAIL hold_after_reset got valid=%b out=%h expected 0/0000", valid, out);
    end
  endtask

  task automatic test_small_instance();
    tick(1'b1, 1'b1, 2'b00, 4'd2, 8'd0);
    checks++;
    if (out2 !== 4'h4 || idx2 !== 2'd2) begin
      errors++;
      $display("FAIL small_direct got out=%h idx=%0d expected 4/2", out2, idx2);
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (out2 !== 4'h8 || idx2 !== 2'd3 || wrap2 !== 1'b0) begin
      errors++;
      $display("FAIL small_step got out=%h idx=%0d wrap=%b expected 8/3/0", out2, idx2, wrap2);
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (out2 !== 4'h1 || idx2 !== 2'd0 || wrap2 !== 1'b1 || valid2 !== 1'b1) begin
      errors++;
      $display("FAIL small_wrap got out=%h idx=%0d wrap=%b valid=%b expected 1/0/1/1", out2, idx2, wrap2, valid2);
    end
    tick(1'b1, 1'b1, 2'b01, 4'd0, 8'd0);
    checks++;
    if (wrap2 !== 1'b0 || idx2 !== 2'd1) begin
      errors++;
      $display("FAIL small_wrap_pulse got wrap=%b idx=%0d expected 0/1", wrap2, idx2);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = 4'd0; dwell = 8'd0;
    @(negedge clk);
    test_reset();
    test_direct_sweep();
    test_scan_up();
    test_scan_down();
    test_enable_hold();
    test_dwell_shrink();
    test_mid_reset();
    test_small_instance();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
